// File: rtl/ps_packet_buffer_pkg.sv
// Shared types for the PacketStream store-and-forward buffer.
package ps_packet_buffer_pkg;

  typedef enum logic [0:0] {
    WR_STORE,
    WR_DISCARD
  } wr_state_e;

endpackage

// File: rtl/ps_packet_buffer_ram.sv
// Simple dual-port RAM for ps_packet_buffer: one write port and one registered read port.
module ps_packet_buffer_ram #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned AWIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register doubles as the output holding stage, so it keeps its value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ps_packet_buffer.sv
// Store-and-forward PacketStream FIFO. Define PS_PACKET_BUFFER_DROP_EN to discard oversize
// packets instead of cutting them through when the buffer fills.
module ps_packet_buffer
  import ps_packet_buffer_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] i_dat,
  input  logic              i_val,
  input  logic              i_eop,
  output logic              i_rdy,
  output logic [DWIDTH-1:0] o_dat,
  output logic              o_val,
  output logic              o_eop,
  input  logic              o_rdy,
  output logic              o_drop
);

  localparam logic [AWIDTH:0] ONE = (AWIDTH + 1)'(1);

  logic [AWIDTH:0] r_wr_ptr;
  logic [AWIDTH:0] r_rd_ptr;
  logic [AWIDTH:0] r_cmt_ptr;
  logic [AWIDTH:0] r_pkt_cnt;
  logic            r_rd_active;
  logic            r_o_val;
  logic [DWIDTH:0] w_rdata;

  logic w_full;
  logic w_empty;
  logic w_discard;
  logic w_rewind;
  logic w_wr_en;
  logic w_leave;
  logic w_out_eop;
  logic w_pkt_avail;
  logic w_elig;
  logic w_rd_en;

  // Full is measured against the committed pointer so the word parked in the output
  // stage still occupies a slot.
  assign w_full  = (r_wr_ptr[AWIDTH] != r_cmt_ptr[AWIDTH]) &&
                   (r_wr_ptr[AWIDTH-1:0] == r_cmt_ptr[AWIDTH-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign i_rdy   = ~w_full | w_discard;
  assign w_wr_en = i_val & i_rdy & ~w_discard;

  assign w_leave     = r_o_val & o_rdy;
  assign w_out_eop   = r_o_val & w_rdata[DWIDTH];
  assign w_pkt_avail = (r_pkt_cnt != {{AWIDTH{1'b0}}, w_out_eop});

`ifdef PS_PACKET_BUFFER_DROP_EN
  wr_state_e       r_wr_state;
  logic [AWIDTH:0] r_pkt_start;
  logic            r_drop;

  assign w_discard = (r_wr_state == WR_DISCARD);
  // Partial packet already spans the whole buffer: it can never complete.
  assign w_rewind  = (r_wr_state == WR_STORE) & i_val & w_full & (r_cmt_ptr == r_pkt_start);
  assign w_elig    = ~w_empty & (w_pkt_avail | (r_rd_active & ~w_out_eop));
  assign o_drop    = r_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state  <= WR_STORE;
      r_pkt_start <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      unique case (r_wr_state)
        WR_STORE: begin
          if (w_rewind) begin
            r_wr_state <= WR_DISCARD;
          end else if (w_wr_en && i_eop) begin
            r_pkt_start <= r_wr_ptr + ONE;
          end
        end
        WR_DISCARD: begin
          if (i_val && i_eop) begin
            r_drop     <= 1'b1;
            r_wr_state <= WR_STORE;
          end
        end
        default: r_wr_state <= WR_STORE;
      endcase
    end
  end
`else
  assign w_discard = 1'b0;
  assign w_rewind  = 1'b0;
  // Full with no complete packet would deadlock, so the partial packet is cut through.
  assign w_elig    = ~w_empty & (w_pkt_avail | (r_rd_active & ~w_out_eop) | w_full);
  assign o_drop    = 1'b0;
`endif

  assign w_rd_en = w_elig & (~r_o_val | o_rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cmt_ptr   <= '0;
      r_pkt_cnt   <= '0;
      r_rd_active <= 1'b0;
      r_o_val     <= 1'b0;
    end else begin
      if (w_rewind) begin
        r_wr_ptr <= r_wr_ptr - (AWIDTH + 1)'(1 << AWIDTH);
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ONE;
      end
      if (w_leave) begin
        r_cmt_ptr   <= r_cmt_ptr + ONE;
        r_rd_active <= ~w_rdata[DWIDTH];
      end
      case ({w_wr_en & i_eop, w_leave & w_rdata[DWIDTH]})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      if (w_rd_en) begin
        r_o_val <= 1'b1;
      end else if (w_leave) begin
        r_o_val <= 1'b0;
      end
    end
  end

  ps_packet_buffer_ram #(
    .WIDTH  (DWIDTH + 1),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AWIDTH-1:0]),
    .i_wdata ({i_eop, i_dat}),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[AWIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  assign o_val = r_o_val;
  assign o_dat = w_rdata[DWIDTH-1:0];
  assign o_eop = w_rdata[DWIDTH];

endmodule

// File: tb/tb_ps_packet_buffer.sv
// Directed bench for ps_packet_buffer (AWIDTH=3); the drop scenario runs when
// PS_PACKET_BUFFER_DROP_EN is defined, the cut-through scenario otherwise.
module tb_ps_packet_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_dat;
  logic       i_val;
  logic       i_eop;
  logic       i_rdy;
  logic [7:0] o_dat;
  logic       o_val;
  logic       o_eop;
  logic       o_rdy;
  logic       o_drop;

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int drop_cnt = 0;
  int eop_cyc;

  logic [7:0] q_dat [$];
  logic       q_eop [$];
  int         q_cyc [$];

  ps_packet_buffer #(
    .DWIDTH (8),
    .AWIDTH (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_dat  (i_dat),
    .i_val  (i_val),
    .i_eop  (i_eop),
    .i_rdy  (i_rdy),
    .o_dat  (o_dat),
    .o_val  (o_val),
    .o_eop  (o_eop),
    .o_rdy  (o_rdy),
    .o_drop (o_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_val && o_rdy) begin
        q_dat.push_back(o_dat);
        q_eop.push_back(o_eop);
        q_cyc.push_back(cyc);
      end
      if (o_drop) drop_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_val = 1'b0;
    i_eop = 1'b0;
    i_dat = '0;
    tick();
    tick();
    reset = 1'b0;
    q_dat.delete();
    q_eop.delete();
    q_cyc.delete();
    drop_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    int k;
    i_dat = d;
    i_val = 1'b1;
    i_eop = e;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_rdy) break;
    end
    check("accept", {31'b0, i_rdy}, 32'd1);
    acc_cyc = cyc;
    tick();
    i_val = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int k = 0; k < budget && q_dat.size() < n; k++) tick();
    check("out_count", q_dat.size(), n);
  endtask

  initial begin
    o_rdy = 1'b1;

    // 1: reset values, single 4-word packet, latency
    do_reset();
    @(negedge clk);
    check("rst_o_val", {31'b0, o_val}, 32'd0);
    check("rst_o_drop", {31'b0, o_drop}, 32'd0);
    check("rst_i_rdy", {31'b0, i_rdy}, 32'd1);
    check("rst_o_dat", {24'b0, o_dat}, 32'd0);
    check("rst_o_eop", {31'b0, o_eop}, 32'd0);
    tick();
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    send(8'h14, 1'b1);
    eop_cyc = acc_cyc;
    wait_out(4, 30);
    if (q_dat.size() >= 4) begin
      check("t1_latency", q_cyc[0], eop_cyc + 2);
      for (int i = 0; i < 4; i++) begin
        check("t1_dat", {24'b0, q_dat[i]}, 32'h11 + i);
        check("t1_eop", {31'b0, q_eop[i]}, (i == 3) ? 32'd1 : 32'd0);
        check("t1_contig", q_cyc[i], q_cyc[0] + i);
      end
    end

    // 2: two 3-word packets held off by o_rdy=0, then drained without gaps
    do_reset();
    o_rdy = 1'b0;
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b1);
    send(8'h24, 1'b0);
    send(8'h25, 1'b0);
    send(8'h26, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_val", {31'b0, o_val}, 32'd1);
      check("t2_hold_dat", {24'b0, o_dat}, 32'h21);
    end
    tick();
    o_rdy = 1'b1;
    wait_out(6, 30);
    if (q_dat.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t2_dat", {24'b0, q_dat[i]}, 32'h21 + i);
        check("t2_eop", {31'b0, q_eop[i]}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
        check("t2_contig", q_cyc[i], q_cyc[0] + i);
      end
    end

    // 3: eight 1-word packets fill the buffer; the ninth waits for one read
    do_reset();
    o_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b1);
    i_dat = 8'h39;
    i_val = 1'b1;
    i_eop = 1'b1;
    @(negedge clk);
    check("t3_full_rdy", {31'b0, i_rdy}, 32'd0);
    tick();
    o_rdy = 1'b1;
    @(negedge clk);
    check("t3_read_same_cycle_rdy", {31'b0, i_rdy}, 32'd0);
    check("t3_first_out", {24'b0, o_dat}, 32'h31);
    tick();
    o_rdy = 1'b0;
    @(negedge clk);
    check("t3_after_read_rdy", {31'b0, i_rdy}, 32'd1);
    tick();
    i_val = 1'b0;
    i_eop = 1'b0;
    o_rdy = 1'b1;
    wait_out(9, 40);
    if (q_dat.size() >= 9) begin
      for (int i = 0; i < 9; i++) begin
        check("t3_order", {24'b0, q_dat[i]}, 32'h31 + i);
      end
    end

`ifndef PS_PACKET_BUFFER_DROP_EN
    // 4: 12-word packet larger than the buffer is cut through
    do_reset();
    o_rdy = 1'b1;
    for (int i = 0; i < 12; i++) send(8'h41 + 8'(i), (i == 11));
    wait_out(12, 60);
    if (q_dat.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        check("t4_dat", {24'b0, q_dat[i]}, 32'h41 + i);
        check("t4_eop", {31'b0, q_eop[i]}, (i == 11) ? 32'd1 : 32'd0);
      end
    end
    check("t4_no_drop", drop_cnt, 32'd0);
`else
    // 5: oversize packet discarded between two small packets
    do_reset();
    o_rdy = 1'b1;
    send(8'h51, 1'b0);
    send(8'h52, 1'b1);
    repeat (5) tick();
    for (int i = 0; i < 12; i++) send(8'h61 + 8'(i), (i == 11));
    send(8'h71, 1'b0);
    send(8'h72, 1'b1);
    wait_out(4, 60);
    repeat (10) tick();
    check("t5_count", q_dat.size(), 32'd4);
    if (q_dat.size() >= 4) begin
      check("t5_dat0", {24'b0, q_dat[0]}, 32'h51);
      check("t5_dat1", {24'b0, q_dat[1]}, 32'h52);
      check("t5_dat2", {24'b0, q_dat[2]}, 32'h71);
      check("t5_dat3", {24'b0, q_dat[3]}, 32'h72);
      check("t5_eop1", {31'b0, q_eop[1]}, 32'd1);
      check("t5_eop3", {31'b0, q_eop[3]}, 32'd1);
    end
    check("t5_drop_once", drop_cnt, 32'd1);
`endif

    // 6: reset mid-packet discards the partial packet
    do_reset();
    o_rdy = 1'b1;
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    send(8'h83, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_o_val", {31'b0, o_val}, 32'd0);
    check("t6_i_rdy", {31'b0, i_rdy}, 32'd1);
    tick();
    send(8'h91, 1'b0);
    send(8'h92, 1'b1);
    wait_out(2, 20);
    repeat (5) tick();
    check("t6_count", q_dat.size(), 32'd2);
    if (q_dat.size() >= 2) begin
      check("t6_dat0", {24'b0, q_dat[0]}, 32'h91);
      check("t6_dat1", {24'b0, q_dat[1]}, 32'h92);
      check("t6_eop0", {31'b0, q_eop[0]}, 32'd0);
      check("t6_eop1", {31'b0, q_eop[1]}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
